// File: rtl/rr_sched_pkg.sv
// Shared types, defaults and helpers for the round-robin resource scheduler.
package rr_sched_pkg;

    localparam int unsigned DEF_N    = 4;
    localparam int unsigned DEF_ID_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // Index of the set bit in a one-hot vector (up to 8 lines); zero when none is set.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular-priority picker: first set request at or after ptr, wrapping to 0.
module rr_pick
    import rr_sched_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned ID_W = DEF_ID_W
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_pick_onehot,
    output logic [ID_W-1:0] o_pick_id,
    output logic            o_pick_any
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_masked;
    logic [N-1:0] w_src;
    logic [7:0]   w_oh_ext;

    always_comb begin
        // Requests at or above ptr win; fall back to the full vector to wrap around.
        w_mask        = ~((N'(1) << i_ptr) - N'(1));
        w_masked      = i_req & w_mask;
        w_src         = (|w_masked) ? w_masked : i_req;
        o_pick_onehot = w_src & (~w_src + N'(1));
        w_oh_ext      = '0;
        w_oh_ext[N-1:0] = o_pick_onehot;
        o_pick_id     = ID_W'(onehot_to_idx(w_oh_ext));
        o_pick_any    = |i_req;
    end

endmodule

// File: rtl/rr_resource_scheduler.sv
// Round-robin owner scheduler with request/grant/done handshake and a turnaround gap.
// Define RR_SCHED_TIMEOUT_EN to force-release grants held for MAX_HOLD cycles.
module rr_resource_scheduler
    import rr_sched_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned ID_W     = DEF_ID_W,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N-1:0]    i_req,
    input  logic [N-1:0]    i_done,
    output logic [N-1:0]    o_gnt,
    output logic            o_gnt_valid,
    output logic [ID_W-1:0] o_gnt_id,
    output logic [1:0]      o_state,
    output logic            o_timeout
);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("rr_resource_scheduler: N must be in 2..8");
    end
    if (ID_W != $clog2(N)) begin : g_bad_id_w
        $error("rr_resource_scheduler: ID_W must equal clog2(N)");
    end
    if (HOLD_W < $clog2(MAX_HOLD + 1) || MAX_HOLD < 2) begin : g_bad_hold
        $error("rr_resource_scheduler: HOLD_W too narrow or MAX_HOLD too small");
    end

    state_e          r_state;
    logic [N-1:0]    r_gnt;
    logic            r_gnt_valid;
    logic [ID_W-1:0] r_gnt_id;
    logic [ID_W-1:0] r_ptr;

    logic [N-1:0]    w_pick_onehot;
    logic [ID_W-1:0] w_pick_id;
    logic            w_pick_any;
    logic            w_release;
    logic [ID_W-1:0] w_next_ptr;

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .i_req         (i_req),
        .i_ptr         (r_ptr),
        .o_pick_onehot (w_pick_onehot),
        .o_pick_id     (w_pick_id),
        .o_pick_any    (w_pick_any)
    );

    // Done and abandon by the owner are the same normal release.
    assign w_release  = i_done[r_gnt_id] | ~i_req[r_gnt_id];
    assign w_next_ptr = (r_gnt_id == ID_W'(N - 1)) ? '0 : r_gnt_id + ID_W'(1);

`ifdef RR_SCHED_TIMEOUT_EN
    logic [HOLD_W-1:0] r_hold;
    logic              r_timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (r_state == ST_GRANT) begin
                if (!w_release && r_hold == HOLD_W'(MAX_HOLD - 1)) begin
                    r_timeout <= 1'b1;
                end
                r_hold <= r_hold + HOLD_W'(1);
            end else begin
                r_hold <= '0;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_ptr       <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RELEASE: begin
                    if (w_pick_any) begin
                        r_state     <= ST_GRANT;
                        r_gnt       <= w_pick_onehot;
                        r_gnt_valid <= 1'b1;
                        r_gnt_id    <= w_pick_id;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
`ifdef RR_SCHED_TIMEOUT_EN
                    if (w_release || r_hold == HOLD_W'(MAX_HOLD - 1)) begin
`else
                    if (w_release) begin
`endif
                        r_state     <= ST_RELEASE;
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= w_next_ptr;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_gnt       <= '0;
                    r_gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_gnt_valid = r_gnt_valid;
    assign o_gnt_id    = r_gnt_id;
    assign o_state     = r_state;

endmodule

// File: tb/tb_rr_resource_scheduler.sv
// Scoreboard bench for rr_resource_scheduler: a behavioural model queues expected outputs per cycle.
module tb_rr_resource_scheduler;

    localparam int N        = 4;
    localparam int ID_W     = 2;
    localparam int MAX_HOLD = 4;
`ifdef RR_SCHED_TIMEOUT_EN
    localparam bit TO_EN    = 1'b1;
`else
    localparam bit TO_EN    = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0]    gnt;
        logic [ID_W-1:0] id;
        logic [1:0]      st;
        logic            to;
    } exp_t;

    logic            clk = 1'b0;
    logic            i_rst;
    logic [N-1:0]    i_req;
    logic [N-1:0]    i_done;
    logic [N-1:0]    o_gnt;
    logic            o_gnt_valid;
    logic [ID_W-1:0] o_gnt_id;
    logic [1:0]      o_state;
    logic            o_timeout;

    int n_checks = 0;
    int n_fails  = 0;

    exp_t exp_q[$];

    // Reference model state
    int           m_state = 0;
    int           m_id    = 0;
    int           m_ptr   = 0;
    int           m_hold  = 0;
    logic [N-1:0] m_gnt   = '0;
    logic         m_to    = 1'b0;

    always #5 clk = ~clk;

    rr_resource_scheduler #(
        .N        (N),
        .ID_W     (ID_W),
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (5)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_done      (i_done),
        .o_gnt       (o_gnt),
        .o_gnt_valid (o_gnt_valid),
        .o_gnt_id    (o_gnt_id),
        .o_state     (o_state),
        .o_timeout   (o_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int scan_from(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] done, input logic rst);
        int w;
        if (rst) begin
            m_state = 0; m_id = 0; m_ptr = 0; m_hold = 0; m_gnt = '0; m_to = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_state == 1) begin
            if (done[m_id] || !req[m_id]) begin
                m_state = 2; m_gnt = '0; m_ptr = (m_id + 1) % N;
            end else if (TO_EN && m_hold == MAX_HOLD - 1) begin
                m_state = 2; m_gnt = '0; m_ptr = (m_id + 1) % N; m_to = 1'b1;
            end else begin
                m_hold++;
            end
        end else begin
            w = scan_from(req, m_ptr);
            if (w >= 0) begin
                m_state = 1; m_id = w; m_gnt = '0; m_gnt[w] = 1'b1; m_hold = 0;
            end else begin
                m_state = 0;
            end
        end
    endtask

    // Drive one cycle, queue the model's prediction, then compare after the edge.
    task automatic step(input logic [N-1:0] req, input logic [N-1:0] done, input logic rst);
        exp_t e;
        i_req  = req;
        i_done = done;
        i_rst  = rst;
        model_step(req, done, rst);
        exp_q.push_back('{gnt: m_gnt, id: ID_W'(m_id), st: 2'(m_state), to: m_to});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("gnt", 32'(o_gnt), 32'(e.gnt));
        check_eq("gnt_valid", 32'(o_gnt_valid), 32'(e.gnt != '0));
        check_eq("gnt_id", 32'(o_gnt_id), 32'(e.id));
        check_eq("state", 32'(o_state), 32'(e.st));
        check_eq("timeout", 32'(o_timeout), 32'(e.to));
    endtask

    initial begin
        logic [N-1:0] order [5];
        logic [N-1:0] exp_order [5];
        int gi;
        int run_len;
        int n_to;
        bit broken;

        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;

        // Reset with all requesting
        step(4'b1111, 4'b0000, 1'b1);
        step(4'b1111, 4'b0000, 1'b1);
        check_eq("rst_gnt", 32'(o_gnt), 32'h0);
        check_eq("rst_state", 32'(o_state), 32'h0);

        // Single requester
        step(4'b0001, 4'b0000, 1'b0);
        check_eq("single_gnt", 32'(o_gnt), 32'b0001);
        step(4'b0001, 4'b0000, 1'b0);
        step(4'b0001, 4'b0001, 1'b0);
        check_eq("single_release", 32'(o_state), 32'd2);
        step(4'b0000, 4'b0000, 1'b0);
        check_eq("single_idle", 32'(o_state), 32'd0);

        // Full rotation from ptr=0
        step(4'b0000, 4'b0000, 1'b1);
        gi = 0;
        for (int t = 0; t < 10; t++) begin
            step(4'b1111, (t % 2 == 1) ? m_gnt : 4'b0000, 1'b0);
            if (t % 2 == 0) begin
                order[gi] = o_gnt;
                gi++;
            end else begin
                check_eq("rot_gap", 32'(o_gnt), 32'h0);
            end
        end
        for (int k = 0; k < 5; k++) check_eq("rot_order", 32'(order[k]), 32'(exp_order[k]));

        // Wrap and skip
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0100, 4'b0000, 1'b0);
        step(4'b0100, 4'b0100, 1'b0);
        step(4'b0101, 4'b0000, 1'b0);
        check_eq("wrap_gnt", 32'(o_gnt), 32'b0001);
        step(4'b0101, 4'b0001, 1'b0);
        step(4'b0100, 4'b0000, 1'b0);
        check_eq("skip_gnt", 32'(o_gnt), 32'b0100);

        // Reset mid-tenure, then ptr back at 0
        step(4'b0100, 4'b0000, 1'b1);
        check_eq("midrst_gnt", 32'(o_gnt), 32'h0);
        check_eq("midrst_state", 32'(o_state), 32'd0);
        step(4'b1111, 4'b0000, 1'b0);
        check_eq("midrst_ptr0", 32'(o_gnt), 32'b0001);

        // Stray done and abandon
        step(4'b1111, 4'b0001, 1'b0);
        step(4'b0010, 4'b0000, 1'b0);
        check_eq("stray_pre", 32'(o_gnt), 32'b0010);
        step(4'b0010, 4'b0100, 1'b0);
        check_eq("stray_gnt", 32'(o_gnt), 32'b0010);
        check_eq("stray_state", 32'(o_state), 32'd1);
        step(4'b0100, 4'b0000, 1'b0);
        check_eq("abandon_state", 32'(o_state), 32'd2);
        step(4'b1001, 4'b0000, 1'b0);
        check_eq("abandon_ptr2", 32'(o_gnt), 32'b1000);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);

        // Long hold: force release with the timeout build, indefinite hold without
        run_len = 0;
        n_to    = 0;
        broken  = 1'b0;
        for (int t = 0; t < 50; t++) begin
            step(4'b0001, 4'b0000, 1'b0);
            if (o_gnt == 4'b0001 && !broken) run_len++;
            else broken = 1'b1;
            if (o_timeout) n_to++;
        end
        check_eq("hold_run", 32'(run_len), TO_EN ? 32'd4 : 32'd50);
        check_eq("hold_timeouts", 32'(n_to), TO_EN ? 32'd10 : 32'd0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        check_eq("final_idle", 32'(o_state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
